// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline: ID/EX, EX/MEM, MEM/WB registers with bubbles,
// global hold, sticky malformed-bundle flag and a retired-instruction counter.
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   Ctrl_i[7:0]: ID bundle. Valid_i, Stall_i, Flush_i, Hold_i: ID-side controls.
//   EX_*_o, MEM_*_o, WB_*_o: per-stage strobes.
//   Err_o: sticky malformed flag. Retired_o: wrapping retired count.
module ctrl_pipe #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           Ctrl_i,
  input  logic                 Valid_i,
  input  logic                 Stall_i,
  input  logic                 Flush_i,
  input  logic                 Hold_i,
  output logic                 EX_Valid_o,
  output logic                 EX_ALUSrc_o,
  output logic [1:0]           EX_ALUOp_o,
  output logic                 EX_RegDst_o,
  output logic                 EX_MemRead_o,
  output logic                 EX_RegWrite_o,
  output logic                 MEM_Valid_o,
  output logic                 MEM_MemRead_o,
  output logic                 MEM_MemWrite_o,
  output logic                 MEM_RegWrite_o,
  output logic                 WB_Valid_o,
  output logic                 WB_RegWrite_o,
  output logic                 WB_MemtoReg_o,
  output logic                 Err_o,
  output logic [CNT_WIDTH-1:0] Retired_o
);

  logic [7:0]           ex_q, ex_d;
  logic                 exv_q, exv_d;
  logic [3:0]           mem_q, mem_d;
  logic                 memv_q, memv_d;
  logic [1:0]           wb_q, wb_d;
  logic                 wbv_q, wbv_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;

  logic accept;
  logic bad;
  logic take;

  assign accept = Valid_i & ~Stall_i & ~Flush_i;
  // A bundle asking for both a load and a store is dropped as a bubble.
  assign bad    = accept & Ctrl_i[2] & Ctrl_i[3];
  assign take   = accept & ~bad;

  always_comb begin
    ex_d   = ex_q;
    exv_d  = exv_q;
    mem_d  = mem_q;
    memv_d = memv_q;
    wb_d   = wb_q;
    wbv_d  = wbv_q;
    err_d  = err_q;
    ret_d  = ret_q;
    if (!Hold_i) begin
      ex_d   = take ? Ctrl_i : 8'h00;
      exv_d  = take;
      mem_d  = ex_q[3:0];
      memv_d = exv_q;
      wb_d   = mem_q[1:0];
      wbv_d  = memv_q;
      err_d  = err_q | bad;
      ret_d  = ret_q + {{(CNT_WIDTH-1){1'b0}}, wbv_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q   <= '0;
      exv_q  <= 1'b0;
      mem_q  <= '0;
      memv_q <= 1'b0;
      wb_q   <= '0;
      wbv_q  <= 1'b0;
      err_q  <= 1'b0;
      ret_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      exv_q  <= exv_d;
      mem_q  <= mem_d;
      memv_q <= memv_d;
      wb_q   <= wb_d;
      wbv_q  <= wbv_d;
      err_q  <= err_d;
      ret_q  <= ret_d;
    end
  end

  assign EX_Valid_o     = exv_q;
  assign EX_ALUSrc_o    = ex_q[4];
  assign EX_ALUOp_o     = ex_q[6:5];
  assign EX_RegDst_o    = ex_q[7];
  assign EX_MemRead_o   = ex_q[2];
  assign EX_RegWrite_o  = ex_q[0];
  assign MEM_Valid_o    = memv_q;
  assign MEM_MemRead_o  = mem_q[2];
  assign MEM_MemWrite_o = mem_q[3];
  assign MEM_RegWrite_o = mem_q[0];
  assign WB_Valid_o     = wbv_q;
  assign WB_RegWrite_o  = wb_q[0];
  assign WB_MemtoReg_o  = wb_q[1];
  assign Err_o          = err_q;
  assign Retired_o      = ret_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: vector table for per-edge stimulus,
// scoreboard queue tracking bundles through EX/MEM/WB and the retire count.
module tb_ctrl_pipe;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    ctrl = '0;
  logic          vld = 1'b0;
  logic          stl = 1'b0;
  logic          fl = 1'b0;
  logic          hld = 1'b0;
  logic          ex_v, ex_src, ex_rd, ex_mr, ex_rw;
  logic [1:0]    ex_op;
  logic          mem_v, mem_mr, mem_mw, mem_rw;
  logic          wb_v, wb_rw, wb_m2r;
  logic          err;
  logic [CW-1:0] ret;

  ctrl_pipe #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .Ctrl_i(ctrl), .Valid_i(vld),
    .Stall_i(stl), .Flush_i(fl), .Hold_i(hld),
    .EX_Valid_o(ex_v), .EX_ALUSrc_o(ex_src), .EX_ALUOp_o(ex_op),
    .EX_RegDst_o(ex_rd), .EX_MemRead_o(ex_mr), .EX_RegWrite_o(ex_rw),
    .MEM_Valid_o(mem_v), .MEM_MemRead_o(mem_mr),
    .MEM_MemWrite_o(mem_mw), .MEM_RegWrite_o(mem_rw),
    .WB_Valid_o(wb_v), .WB_RegWrite_o(wb_rw), .WB_MemtoReg_o(wb_m2r),
    .Err_o(err), .Retired_o(ret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] b;
  } ent_t;

  typedef struct {
    logic       v, s, f;
    logic [7:0] c;
    logic       ev;
    logic [7:0] eb;
    logic       er;
  } vec_t;

  ent_t          sb[$];
  logic [CW-1:0] exp_ret;
  int            total = 0;
  int            passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  // One clock edge: drive, advance, update the scoreboard, compare.
  task automatic step(input logic r, input logic h, input logic v,
                      input logic s, input logic f, input logic [7:0] c,
                      input logic ev, input logic [7:0] eb,
                      input logic er);
    ent_t w, m, e, old;
    rst = r; hld = h; vld = v; stl = s; fl = f; ctrl = c;
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      for (int i = 0; i < 3; i++) sb.push_back('0);
      exp_ret = '0;
    end else if (!h) begin
      old = sb.pop_front();
      exp_ret = exp_ret + {{(CW-1){1'b0}}, old.v};
      sb.push_back('{v: ev, b: eb});
    end
    w = sb[0]; m = sb[1]; e = sb[2];
    chk("ex", {26'd0, ex_rd, ex_op, ex_src, ex_mr, ex_rw, ex_v},
        {26'd0, e.b[7], e.b[6:5], e.b[4], e.b[2], e.b[0], e.v});
    chk("mem", {28'd0, mem_mw, mem_mr, mem_rw, mem_v},
        {28'd0, m.b[3], m.b[2], m.b[0], m.v});
    chk("wb", {29'd0, wb_m2r, wb_rw, wb_v},
        {29'd0, w.b[1], w.b[0], w.v});
    chk("err", {31'd0, err}, {31'd0, er});
    chk("retired", {{(32-CW){1'b0}}, ret}, {{(32-CW){1'b0}}, exp_ret});
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 0, 0, 8'h01, 1, 8'h01, 0};
    tbl[1]  = '{0, 0, 0, 8'h01, 0, 8'h00, 0};
    tbl[2]  = '{1, 1, 0, 8'h8B, 0, 8'h00, 0};
    tbl[3]  = '{1, 0, 0, 8'h8B, 1, 8'h8B, 0};
    tbl[4]  = '{1, 0, 0, 8'h01, 1, 8'h01, 0};
    tbl[5]  = '{1, 0, 1, 8'h03, 0, 8'h00, 0};
    tbl[6]  = '{1, 0, 0, 8'h08, 1, 8'h08, 0};
    tbl[7]  = '{1, 1, 1, 8'h7F, 0, 8'h00, 0};
    tbl[8]  = '{1, 0, 0, 8'h70, 1, 8'h70, 0};
    tbl[9]  = '{1, 0, 0, 8'h16, 1, 8'h16, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 8'h00, 0};
    tbl[11] = '{1, 0, 0, 8'h0C, 0, 8'h00, 1};
    tbl[12] = '{1, 0, 0, 8'h01, 1, 8'h01, 1};
    tbl[13] = '{1, 0, 0, 8'h04, 1, 8'h04, 1};
    tbl[14] = '{0, 0, 0, 8'h00, 0, 8'h00, 1};
    tbl[15] = '{0, 0, 0, 8'h00, 0, 8'h00, 1};

    step(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);

    foreach (tbl[i])
      step(0, 0, tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].c,
           tbl[i].ev, tbl[i].eb, tbl[i].er);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1);

    // Sticky error survives traffic and only reset clears it.
    step(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);

    // Fill all stages, hold three edges with noisy inputs, then drain.
    step(0, 0, 1, 0, 0, 8'h01, 1, 8'h01, 0);
    step(0, 0, 1, 0, 0, 8'h02, 1, 8'h02, 0);
    step(0, 0, 1, 0, 0, 8'h0B, 1, 8'h0B, 0);
    step(0, 1, 1, 0, 0, 8'h0C, 0, 8'h00, 0);
    step(0, 1, 1, 1, 1, 8'hFF, 0, 8'h00, 0);
    step(0, 1, 1, 0, 0, 8'h8B, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("hold_retired", {28'd0, ret}, 32'd3);

    // 17 retirements wrap a 4-bit counter to 1.
    step(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, 8'h01, 1, 8'h01, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("wrap_retired", {28'd0, ret}, 32'd1);

    // Mid-stream reset with hold also asserted: reset wins, all cleared.
    step(0, 0, 1, 0, 0, 8'h0C, 0, 8'h00, 1);
    step(0, 0, 1, 0, 0, 8'h01, 1, 8'h01, 1);
    step(0, 0, 1, 0, 0, 8'h03, 1, 8'h03, 1);
    step(1, 1, 1, 0, 0, 8'h01, 0, 8'h00, 0);
    chk("rst_all", {13'd0, ex_v, ex_src, ex_op, ex_rd, ex_mr, ex_rw,
                    mem_v, mem_mr, mem_mw, mem_rw, wb_v, wb_rw, wb_m2r,
                    err, ret}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("rst_retired", {28'd0, ret}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
